bram_lane_router: RTL and testbench
===================================

# bram_lane_router

Parametrised successor to the BRAM-controller address decoder. It accepts 32-bit word requests over a valid/ready front end and decodes the top address bits into NUM_TGT byte-wide buffer targets plus one control/status register (CSR) region. Each word access is serialised into per-byte-lane target accesses. Target read latency is configurable. Convolution/FC configuration and done status live in the CSR region, so they are no longer top-level pins.

## Interface
- ADDR_W, 22: request byte-address width.
- SEL_W, 3: region-select field width, taken from req_addr[ADDR_W-1 -: SEL_W].
- NUM_TGT, 3: byte-wide targets, 1..2^SEL_W-1. Region 2^SEL_W-1 is the CSR region.
- LOCAL_AW, 17: target pointer width. Must satisfy LOCAL_AW <= ADDR_W-SEL_W.
- RD_LAT, 1: cycles from tgt_rden to valid tgt_rdata, range 1..4.
- DONE_W, 18: width of the done status vector.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_W  byte address, word aligned; bits [1:0] are ignored.
- req_wdata  in  32  write data.
- req_we  in  4  byte write enables; 4'b0000 means read.
- rsp_valid  out  1  one-cycle response strobe. No backpressure.
- rsp_rdata  out  32  read data, held until the next response.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- tgt_wren  out  NUM_TGT  one-hot byte write strobe.
- tgt_rden  out  NUM_TGT  one-hot byte read strobe.
- tgt_ptr  out  LOCAL_AW  shared byte pointer, {req_addr[LOCAL_AW-1:2], lane[1:0]}.
- tgt_wdata  out  8  shared write byte, req_wdata[8*lane+7 -: 8].
- tgt_rdata  in  8*NUM_TGT  target t's read data is bits [8t+7 -: 8].
- start_o  out  2  one-cycle pulse of the CTRL write value (1 = SA start, 2 = FC start).
- nth_conv_o 2, ofmap_size_o 5, ifmap_ch_o 6, in_node_num_o 7, out_node_num_o 7  out  configuration registers.
- done_i  in  DONE_W  done event bits, sampled every cycle.

## Operation
- FSM states: IDLE, LANE, WAIT, RESP.
- Request is latched on req_valid & req_ready. Region r is the select field.
- Target region (r < NUM_TGT), write: LANE visits lanes 0..3 in ascending order, one cycle per lane whose req_we bit is set; disabled lanes are skipped. tgt_wren[r] is asserted for each enabled lane, then the FSM goes to RESP.
- Target region, read: LANE issues tgt_rden[r] for lanes 0..3 on consecutive cycles. A lane-index delay line of depth RD_LAT steers each returning byte into rdata byte lane k. WAIT holds until lane 3 has been captured, then goes to RESP.
- CSR region (r = 2^SEL_W-1), word offset req_addr[3:2]. Write fields honour req_we per byte.
  - 0 CTRL: a write pulses start_o = wdata[1:0]. Reads return 0.
  - 1 CONV: [1:0] nth_conv, [12:8] ofmap_size, [21:16] ifmap_ch. Read/write.
  - 2 FC: [6:0] in_node_num, [14:8] out_node_num. Read/write.
  - 3 DONE: sticky register, done_sticky |= done_i every cycle. Writing 1 clears the corresponding bit. If set and clear hit the same bit in the same cycle, set wins. Reads return the value zero-extended to 32 bits.
  - Unused bits read 0.
- Any other region: no side effect; response has rsp_err=1 and rsp_rdata=0.
- RESP: rsp_valid=1 for one cycle, then IDLE. rsp_err=0 for mapped accesses.
- Reset values:
  - All outputs are 0 except req_ready=1.
  - All CSRs and done_sticky are 0.
  - FSM is in IDLE.
- Reset asserted mid-transaction: the transaction is dropped with no response, and no further target strobes are issued.

## Timing
- T0 is the acceptance cycle. Target strobes, pointer and write data are registered outputs.
- Target write with n enabled lanes: strobes in T1..Tn, rsp_valid in T(n+1), req_ready high again in T(n+2).
- Target read: tgt_rden in T1..T4, lane k byte sampled at the end of T(1+k+RD_LAT), rsp_valid in T(5+RD_LAT), req_ready in T(6+RD_LAT).
- CSR access: register update and start_o pulse in T1, rsp_valid in T2.
- Unmapped access: rsp_valid with rsp_err in T1.
- Exactly one of tgt_wren/tgt_rden bits is high per cycle, or none.
- req_valid is ignored while req_ready=0.

## Test plan
- Write 0xA1B2C3D4 to region 1, addr word 5, we=1111 -> tgt_wren[1] in T1..T4 with ptr 20,21,22,23 and data D4,C3,B2,A1; rsp_valid in T5.
- Write, we=0101 -> exactly 2 strobes (lanes 0, 2, ptrs 4w+0 and 4w+2); rsp_valid in T3.
- Read of region 0 with RD_LAT=1 and RD_LAT=3, target model returns ptr[7:0] -> rsp_rdata={ptr3,ptr2,ptr1,ptr0}; rsp_valid in T6 and T8 respectively.
- CSR: write CONV=0x0012_0A03 -> nth_conv=3, ofmap_size=10, ifmap_ch=18. CTRL write 2 -> start_o=2 for exactly one cycle. Pulse done_i[4] -> DONE reads 0x10. Write 0x10 to DONE while done_i[4]=1 -> bit stays set.
- Region 5 with NUM_TGT=3 -> rsp_err=1, rsp_rdata=0, no target strobes.
- Assert rst during T2 of a read -> all outputs reset, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/bram_lane_router.sv
`default_nettype none
// ============================================================================
// bram_lane_router: serialises 32-bit word requests into byte-lane target
// accesses and hosts the conv/FC configuration + done-status CSR block.
// Revision: 1.0
// ============================================================================
module bram_lane_router #(
  parameter int ADDR_W   = 22,
  parameter int SEL_W    = 3,
  parameter int NUM_TGT  = 3,
  parameter int LOCAL_AW = 17,
  parameter int RD_LAT   = 1,
  parameter int DONE_W   = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_we,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [NUM_TGT-1:0]    tgt_wren,
  output logic [NUM_TGT-1:0]    tgt_rden,
  output logic [LOCAL_AW-1:0]   tgt_ptr,
  output logic [7:0]            tgt_wdata,
  input  logic [8*NUM_TGT-1:0]  tgt_rdata,
  output logic [1:0]            start_o,
  output logic [1:0]            nth_conv_o,
  output logic [4:0]            ofmap_size_o,
  output logic [5:0]            ifmap_ch_o,
  output logic [6:0]            in_node_num_o,
  output logic [6:0]            out_node_num_o,
  input  logic [DONE_W-1:0]     done_i
);

  localparam logic [SEL_W-1:0] CSR_SEL = '1;

  typedef enum logic [1:0] {IDLE, LANE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [LOCAL_AW-3:0]   base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            we_q, we_d;
  logic [NUM_TGT-1:0]    tgt_oh_q, tgt_oh_d;
  logic                  csr_q, csr_d;
  logic [1:0]            lane_q, lane_d;
  logic [NUM_TGT-1:0]    wren_q, wren_d, rden_q, rden_d;
  logic [LOCAL_AW-1:0]   ptr_q, ptr_d;
  logic [7:0]            twdata_q, twdata_d;
  logic [31:0]           rbuf_q, rbuf_d, rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [1:0]            start_q, start_d, nth_q, nth_d;
  logic [4:0]            ofm_q, ofm_d;
  logic [5:0]            ich_q, ich_d;
  logic [6:0]            inn_q, inn_d, outn_q, outn_d;
  logic [DONE_W-1:0]     done_q, done_d, w_clr;

  logic [RD_LAT-1:0]     rd_vld_q;
  logic [1:0]            rd_lane_q [RD_LAT];

  logic [SEL_W-1:0]      w_sel;
  logic [NUM_TGT-1:0]    w_sel_oh;
  logic                  w_is_csr, w_is_tgt;
  logic [3:0]            w_mask_in, w_mask_q;
  logic [2:0]            w_fl_in, w_fl_nx;
  logic [31:0]           w_bmask, w_clr_word, w_csr_rd;
  logic [7:0]            w_rbyte;
  logic                  unused_ok;

  // Lowest enabled lane at or above 'from'; MSB flags that one was found.
  function automatic logic [2:0] first_lane(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] l);
    case (l)
      2'd0:    get_byte = w[7:0];
      2'd1:    get_byte = w[15:8];
      2'd2:    get_byte = w[23:16];
      default: get_byte = w[31:24];
    endcase
  endfunction

  assign w_sel      = req_addr[ADDR_W-1 -: SEL_W];
  assign w_is_csr   = (w_sel == CSR_SEL);
  assign w_is_tgt   = |w_sel_oh;
  assign w_mask_in  = (req_we == 4'b0000) ? 4'hF : req_we;
  assign w_mask_q   = (we_q == 4'b0000) ? 4'hF : we_q;
  assign w_fl_in    = first_lane(w_mask_in, 3'd0);
  assign w_fl_nx    = first_lane(w_mask_q, {1'b0, lane_q} + 3'd1);
  assign w_bmask    = {{8{req_we[3]}}, {8{req_we[2]}}, {8{req_we[1]}}, {8{req_we[0]}}};
  assign w_clr_word = req_wdata & w_bmask;
  assign unused_ok  = ^{req_addr, w_clr_word};

  always_comb begin
    w_sel_oh = '0;
    for (int t = 0; t < NUM_TGT; t++) w_sel_oh[t] = (w_sel == SEL_W'(t));
  end

  always_comb begin
    w_rbyte = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      if (tgt_oh_q[t]) w_rbyte = tgt_rdata[8*t +: 8];
    end
  end

  always_comb begin
    w_csr_rd = '0;
    case (base_q[1:0])
      2'd1: begin
        w_csr_rd[1:0]   = nth_q;
        w_csr_rd[12:8]  = ofm_q;
        w_csr_rd[21:16] = ich_q;
      end
      2'd2: begin
        w_csr_rd[6:0]   = inn_q;
        w_csr_rd[14:8]  = outn_q;
      end
      2'd3:    w_csr_rd[DONE_W-1:0] = done_q;
      default: w_csr_rd = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    tgt_oh_d = tgt_oh_q;
    csr_d    = csr_q;
    lane_d   = lane_q;
    wren_d   = '0;
    rden_d   = '0;
    ptr_d    = ptr_q;
    twdata_d = twdata_q;
    rbuf_d   = rbuf_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    start_d  = '0;
    nth_d    = nth_q;
    ofm_d    = ofm_q;
    ich_d    = ich_q;
    inn_d    = inn_q;
    outn_d   = outn_q;
    w_clr    = '0;

    // Returning read bytes are steered by the delayed lane index.
    if (rd_vld_q[RD_LAT-1]) begin
      for (int k = 0; k < 4; k++) begin
        if (rd_lane_q[RD_LAT-1] == 2'(k)) rbuf_d[8*k +: 8] = w_rbyte;
      end
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d   = req_addr[LOCAL_AW-1:2];
          wdata_d  = req_wdata;
          we_d     = req_we;
          tgt_oh_d = w_sel_oh;
          csr_d    = w_is_csr;
          err_d    = 1'b0;
          if (w_is_tgt) begin
            lane_d   = w_fl_in[1:0];
            ptr_d    = {req_addr[LOCAL_AW-1:2], w_fl_in[1:0]};
            twdata_d = get_byte(req_wdata, w_fl_in[1:0]);
            rbuf_d   = '0;
            if (req_we != 4'b0000) wren_d = w_sel_oh;
            else                   rden_d = w_sel_oh;
            state_d  = LANE;
          end else if (w_is_csr) begin
            case (req_addr[3:2])
              2'd0: if (req_we[0]) start_d = req_wdata[1:0];
              2'd1: begin
                if (req_we[0]) nth_d = req_wdata[1:0];
                if (req_we[1]) ofm_d = req_wdata[12:8];
                if (req_we[2]) ich_d = req_wdata[21:16];
              end
              2'd2: begin
                if (req_we[0]) inn_d  = req_wdata[6:0];
                if (req_we[1]) outn_d = req_wdata[14:8];
              end
              default: w_clr = w_clr_word[DONE_W-1:0];
            endcase
            state_d = WAIT;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      LANE: begin
        if (w_fl_nx[2]) begin
          lane_d   = w_fl_nx[1:0];
          ptr_d    = {base_q, w_fl_nx[1:0]};
          twdata_d = get_byte(wdata_q, w_fl_nx[1:0]);
          if (we_q != 4'b0000) wren_d = tgt_oh_q;
          else                 rden_d = tgt_oh_q;
        end else if (we_q != 4'b0000) begin
          rdata_d = '0;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (csr_q) begin
          rdata_d = (we_q == 4'b0000) ? w_csr_rd : 32'd0;
          state_d = RESP;
        end else if (rd_vld_q[RD_LAT-1] && (rd_lane_q[RD_LAT-1] == 2'd3)) begin
          rdata_d = rbuf_d;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set wins over a simultaneous write-1-to-clear.
    done_d = (done_q & ~w_clr) | done_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      wdata_q  <= '0;
      we_q     <= '0;
      tgt_oh_q <= '0;
      csr_q    <= 1'b0;
      lane_q   <= '0;
      wren_q   <= '0;
      rden_q   <= '0;
      ptr_q    <= '0;
      twdata_q <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      start_q  <= '0;
      nth_q    <= '0;
      ofm_q    <= '0;
      ich_q    <= '0;
      inn_q    <= '0;
      outn_q   <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      tgt_oh_q <= tgt_oh_d;
      csr_q    <= csr_d;
      lane_q   <= lane_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      ptr_q    <= ptr_d;
      twdata_q <= twdata_d;
      rbuf_q   <= rbuf_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      start_q  <= start_d;
      nth_q    <= nth_d;
      ofm_q    <= ofm_d;
      ich_q    <= ich_d;
      inn_q    <= inn_d;
      outn_q   <= outn_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_lane_q[i] <= '0;
    end else begin
      rd_vld_q[0]  <= |rden_q;
      rd_lane_q[0] <= lane_q;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_lane_q[i] <= rd_lane_q[i-1];
      end
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign rsp_valid      = (state_q == RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = err_q;
  assign tgt_wren       = wren_q;
  assign tgt_rden       = rden_q;
  assign tgt_ptr        = ptr_q;
  assign tgt_wdata      = twdata_q;
  assign start_o        = start_q;
  assign nth_conv_o     = nth_q;
  assign ofmap_size_o   = ofm_q;
  assign ifmap_ch_o     = ich_q;
  assign in_node_num_o  = inn_q;
  assign out_node_num_o = outn_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_lane_router.sv
`default_nettype none
// ============================================================================
// tb_bram_lane_router: directed, self-checking bench (RD_LAT=1 and RD_LAT=3).
// Revision: 1.0
// ============================================================================
module tb_bram_lane_router;

  logic        clk, rst;
  logic        req_valid, req_ready, rsp_valid, rsp_err;
  logic [21:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata;
  logic [3:0]  req_we;
  logic [2:0]  tgt_wren, tgt_rden;
  logic [16:0] tgt_ptr;
  logic [7:0]  tgt_wdata;
  logic [23:0] tgt_rdata;
  logic [1:0]  start_o, nth_conv_o;
  logic [4:0]  ofmap_size_o;
  logic [5:0]  ifmap_ch_o;
  logic [6:0]  in_node_num_o, out_node_num_o;
  logic [17:0] done_i;

  logic        d3_valid, d3_ready, d3_rsp_valid, d3_rsp_err;
  logic [21:0] d3_addr;
  logic [31:0] d3_wdata, d3_rsp_rdata;
  logic [3:0]  d3_we;
  logic [2:0]  d3_wren, d3_rden;
  logic [16:0] d3_ptr;
  logic [7:0]  d3_twdata;
  logic [23:0] d3_trdata;
  logic [1:0]  d3_start, d3_nth;
  logic [4:0]  d3_ofm;
  logic [5:0]  d3_ich;
  logic [6:0]  d3_inn, d3_outn;
  logic [17:0] d3_done;

  bram_lane_router #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tgt_wren(tgt_wren), .tgt_rden(tgt_rden), .tgt_ptr(tgt_ptr),
    .tgt_wdata(tgt_wdata), .tgt_rdata(tgt_rdata), .start_o(start_o),
    .nth_conv_o(nth_conv_o), .ofmap_size_o(ofmap_size_o), .ifmap_ch_o(ifmap_ch_o),
    .in_node_num_o(in_node_num_o), .out_node_num_o(out_node_num_o), .done_i(done_i)
  );

  bram_lane_router #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(d3_valid), .req_ready(d3_ready),
    .req_addr(d3_addr), .req_wdata(d3_wdata), .req_we(d3_we),
    .rsp_valid(d3_rsp_valid), .rsp_rdata(d3_rsp_rdata), .rsp_err(d3_rsp_err),
    .tgt_wren(d3_wren), .tgt_rden(d3_rden), .tgt_ptr(d3_ptr),
    .tgt_wdata(d3_twdata), .tgt_rdata(d3_trdata), .start_o(d3_start),
    .nth_conv_o(d3_nth), .ofmap_size_o(d3_ofm), .ifmap_ch_o(d3_ich),
    .in_node_num_o(d3_inn), .out_node_num_o(d3_outn), .done_i(d3_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target models: target t returns ptr[7:0] + 16*t exactly RD_LAT cycles after rden.
  logic       m1_v;
  logic [7:0] m1_p;
  logic [2:0] m3_v;
  logic [7:0] m3_p [3];

  always @(posedge clk) begin
    m1_v    <= |tgt_rden;
    m1_p    <= tgt_ptr[7:0];
    m3_v    <= {m3_v[1:0], |d3_rden};
    m3_p[0] <= d3_ptr[7:0];
    m3_p[1] <= m3_p[0];
    m3_p[2] <= m3_p[1];
  end

  always_comb begin
    tgt_rdata = '0;
    d3_trdata = '0;
    for (int t = 0; t < 3; t++) begin
      tgt_rdata[8*t +: 8] = m1_v    ? m1_p    + 8'(16*t) : 8'hEE;
      d3_trdata[8*t +: 8] = m3_v[2] ? m3_p[2] + 8'(16*t) : 8'hEE;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [2:0]  wr_tr [16];
  logic [2:0]  rd_tr [16];
  logic [16:0] ptr_tr [16];
  logic [7:0]  wd_tr [16];
  logic [1:0]  st_tr [16];
  int          rsp_cyc, rsp_cnt, n_strb, st_cnt;
  logic [31:0] rsp_d;
  logic        rsp_e;

  // One transaction on dut: T0 at the first negedge, records cycles T1..T15.
  task automatic run(input logic [21:0] a, input logic [31:0] d, input logic [3:0] we,
                     input logic [17:0] dn);
    @(negedge clk);
    req_addr = a; req_wdata = d; req_we = we; req_valid = 1'b1; done_i = dn;
    check_eq("ready_T0", 32'(req_ready), 32'd1);
    rsp_cyc = 0; rsp_cnt = 0; n_strb = 0; st_cnt = 0; rsp_d = '0; rsp_e = 1'b0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if (k == 1) begin req_valid = 1'b0; done_i = '0; end
      wr_tr[k]  = tgt_wren;
      rd_tr[k]  = tgt_rden;
      ptr_tr[k] = tgt_ptr;
      wd_tr[k]  = tgt_wdata;
      st_tr[k]  = start_o;
      n_strb += $countones({tgt_wren, tgt_rden});
      if (start_o != 2'b00) st_cnt++;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc == 0) begin rsp_cyc = k; rsp_d = rsp_rdata; rsp_e = rsp_err; end
      end
    end
  endtask

  localparam logic [21:0] CSR = 22'(7) << 19;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = '0; done_i = '0;
    d3_valid = 1'b0; d3_addr = '0; d3_wdata = '0; d3_we = '0; d3_done = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_strobes", 32'({tgt_wren, tgt_rden}), 32'd0);
    check_eq("rst_ptr_wdata", 32'({tgt_ptr, tgt_wdata}), 32'd0);
    check_eq("rst_cfg", 32'({start_o, nth_conv_o, ofmap_size_o, ifmap_ch_o}), 32'd0);
    check_eq("rst_cfg_fc", 32'({in_node_num_o, out_node_num_o, rsp_err}), 32'd0);
    rst = 1'b0;

    // Full-word target write, region 1, word 5.
    run((22'(1) << 19) | 22'd20, 32'hA1B2C3D4, 4'hF, '0);
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("w4_wren_T%0d", k), 32'(wr_tr[k]), 32'h2);
      check_eq($sformatf("w4_ptr_T%0d", k), 32'(ptr_tr[k]), 32'(19 + k));
    end
    check_eq("w4_data_T1", 32'(wd_tr[1]), 32'hD4);
    check_eq("w4_data_T2", 32'(wd_tr[2]), 32'hC3);
    check_eq("w4_data_T3", 32'(wd_tr[3]), 32'hB2);
    check_eq("w4_data_T4", 32'(wd_tr[4]), 32'hA1);
    check_eq("w4_strobes", 32'(n_strb), 32'd4);
    check_eq("w4_rsp_cyc", 32'(rsp_cyc), 32'd5);
    check_eq("w4_rsp_cnt", 32'(rsp_cnt), 32'd1);
    check_eq("w4_err", 32'(rsp_e), 32'd0);

    // Sparse write we=0101, region 2, word 9.
    run((22'(2) << 19) | 22'd36, 32'h11223344, 4'b0101, '0);
    check_eq("w2_wren_T1", 32'(wr_tr[1]), 32'h4);
    check_eq("w2_ptr_T1", 32'(ptr_tr[1]), 32'd36);
    check_eq("w2_data_T1", 32'(wd_tr[1]), 32'h44);
    check_eq("w2_wren_T2", 32'(wr_tr[2]), 32'h4);
    check_eq("w2_ptr_T2", 32'(ptr_tr[2]), 32'd38);
    check_eq("w2_data_T2", 32'(wd_tr[2]), 32'h22);
    check_eq("w2_strobes", 32'(n_strb), 32'd2);
    check_eq("w2_rsp_cyc", 32'(rsp_cyc), 32'd3);

    // Reads, RD_LAT=1.
    run(22'd28, 32'h0, 4'h0, '0);
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("r0_rden_T%0d", k), 32'(rd_tr[k]), 32'h1);
      check_eq($sformatf("r0_ptr_T%0d", k), 32'(ptr_tr[k]), 32'(27 + k));
    end
    check_eq("r0_strobes", 32'(n_strb), 32'd4);
    check_eq("r0_rsp_cyc", 32'(rsp_cyc), 32'd6);
    check_eq("r0_rdata", rsp_d, 32'h1F1E1D1C);
    run((22'(2) << 19) | 22'd12, 32'h0, 4'h0, '0);
    check_eq("r2_rden_T1", 32'(rd_tr[1]), 32'h4);
    check_eq("r2_rdata", rsp_d, 32'h2F2E2D2C);
    check_eq("r2_rsp_cyc", 32'(rsp_cyc), 32'd6);

    // Read on the RD_LAT=3 instance.
    @(negedge clk);
    d3_addr = 22'd28; d3_valid = 1'b1;
    rsp_cyc = 0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      d3_valid = 1'b0;
      if (d3_rsp_valid && rsp_cyc == 0) begin rsp_cyc = k; rsp_d = d3_rsp_rdata; end
    end
    check_eq("r3_rsp_cyc", 32'(rsp_cyc), 32'd8);
    check_eq("r3_rdata", rsp_d, 32'h1F1E1D1C);

    // CSR block.
    run(CSR | 22'd4, 32'h00120A03, 4'hF, '0);
    check_eq("conv_rsp_cyc", 32'(rsp_cyc), 32'd2);
    check_eq("conv_fields", 32'({nth_conv_o, ofmap_size_o, ifmap_ch_o}), 32'({2'd3, 5'd10, 6'd18}));
    check_eq("csr_no_strobes", 32'(n_strb), 32'd0);
    run(CSR | 22'd4, 32'h0, 4'h0, '0);
    check_eq("conv_read", rsp_d, 32'h00120A03);
    run(CSR | 22'd8, 32'h00002A15, 4'b0001, '0);
    check_eq("fc_fields", 32'({in_node_num_o, out_node_num_o}), 32'({7'h15, 7'h00}));
    run(CSR | 22'd8, 32'h0, 4'h0, '0);
    check_eq("fc_read", rsp_d, 32'h00000015);
    run(CSR, 32'h2, 4'hF, '0);
    check_eq("start_T1", 32'(st_tr[1]), 32'd2);
    check_eq("start_once", 32'(st_cnt), 32'd1);
    run(CSR, 32'h0, 4'h0, '0);
    check_eq("ctrl_read", rsp_d, 32'h0);

    @(negedge clk); done_i = 18'h10;
    @(negedge clk); done_i = '0;
    run(CSR | 22'd12, 32'h0, 4'h0, '0);
    check_eq("done_read", rsp_d, 32'h10);
    run(CSR | 22'd12, 32'h10, 4'hF, 18'h10);
    run(CSR | 22'd12, 32'h0, 4'h0, '0);
    check_eq("done_set_wins", rsp_d, 32'h10);
    run(CSR | 22'd12, 32'h10, 4'hF, '0);
    run(CSR | 22'd12, 32'h0, 4'h0, '0);
    check_eq("done_cleared", rsp_d, 32'h0);

    // Unmapped regions.
    run(22'(5) << 19, 32'h0, 4'h0, '0);
    check_eq("unm5_rsp_cyc", 32'(rsp_cyc), 32'd1);
    check_eq("unm5_err", 32'(rsp_e), 32'd1);
    run(22'd12, 32'h0, 4'h0, '0);
    run(22'(3) << 19, 32'hDEADBEEF, 4'hF, '0);
    check_eq("unm3_err", 32'(rsp_e), 32'd1);
    check_eq("unm3_rdata", rsp_d, 32'h0);
    check_eq("unm3_strobes", 32'(n_strb), 32'd0);

    // Reset during T2 of a read.
    @(negedge clk);
    req_addr = 22'd28; req_we = 4'h0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rstmid_rden_T1", 32'(tgt_rden), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rstmid_strobes", 32'({tgt_wren, tgt_rden}), 32'd0);
    check_eq("rstmid_ready", 32'(req_ready), 32'd1);
    check_eq("rstmid_ptr", 32'(tgt_ptr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_strb = 0; rsp_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_strb += $countones({tgt_wren, tgt_rden});
      if (rsp_valid) rsp_cnt++;
    end
    check_eq("rstmid_no_rsp", 32'(rsp_cnt), 32'd0);
    check_eq("rstmid_no_strb", 32'(n_strb), 32'd0);
    run((22'(1) << 19) | 22'd20, 32'hA1B2C3D4, 4'hF, '0);
    check_eq("after_rst_rsp_cyc", 32'(rsp_cyc), 32'd5);
    check_eq("after_rst_strobes", 32'(n_strb), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
